// File: rtl/data_mem_lsu.sv
// Byte-lane RV32 data memory with a request/response handshake, optional wait states
// and fault reporting for misaligned, out-of-range and illegal-size accesses.
module data_mem_lsu #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err
);

   localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
   localparam logic [63:0] MemBytes = 64'(DEPTH_WORDS) * 64'd4;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            resp_valid_q;
   logic [31:0]     resp_rdata_q;
   logic            resp_err_q;

   logic            lat_we, lat_err, lat_uns;
   logic [1:0]      lat_size, lat_off;
   logic [IdxW-1:0] lat_idx;

   logic            accept, acc_err, wr_en;
   logic [3:0]      wr_be;
   logic [31:0]     wr_data;
   logic [IdxW-1:0] req_idx;

   logic [IdxW-1:0] rd_idx;
   logic [1:0]      rd_off, rd_size;
   logic            rd_uns, rd_err, rd_silent;
   logic [31:0]     rd_word, byte_sh, load_data;
   logic [15:0]     rd_half;

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

   assign accept  = req_valid && (state_q == StIdle);
   assign req_idx = req_addr[IdxW+1:2];
   assign wr_en   = accept && req_we && !acc_err && !rst;

   always_comb begin
      acc_err = 1'b0;
      unique case (req_size)
         2'b00:   acc_err = 1'b0;
         2'b01:   acc_err = req_addr[0];
         2'b10:   acc_err = |req_addr[1:0];
         default: acc_err = 1'b1;
      endcase
      if (64'(req_addr) >= MemBytes) acc_err = 1'b1;
   end

   // Store data is replicated across lanes so each lane just takes its own byte.
   always_comb begin
      wr_be   = 4'b0000;
      wr_data = req_wdata;
      unique case (req_size)
         2'b00: begin
            wr_be   = 4'b0001 << req_addr[1:0];
            wr_data = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{req_wdata[15:0]}};
         end
         2'b10:   wr_be = 4'b1111;
         default: wr_be = 4'b0000;
      endcase
   end

   for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
         if (wr_en && wr_be[l]) begin
            mem[req_idx] <= wr_data[8*l +: 8];
         end
      end

      assign rd_word[8*l +: 8] = mem[rd_idx];
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lat_we   <= req_we;
         lat_err  <= acc_err;
         lat_uns  <= req_unsigned;
         lat_size <= req_size;
         lat_off  <= req_addr[1:0];
         lat_idx  <= req_idx;
      end
   end

   // With no wait states the read happens on the accept edge, straight from the request.
   always_comb begin
      if (state_q == StIdle) begin
         rd_idx  = req_idx;
         rd_off  = req_addr[1:0];
         rd_size = req_size;
         rd_uns  = req_unsigned;
         rd_err  = acc_err;
         rd_silent = req_we || acc_err;
      end else begin
         rd_idx  = lat_idx;
         rd_off  = lat_off;
         rd_size = lat_size;
         rd_uns  = lat_uns;
         rd_err  = lat_err;
         rd_silent = lat_we || lat_err;
      end
   end

   always_comb begin
      byte_sh = rd_word >> {rd_off, 3'b000};
      rd_half = rd_off[1] ? rd_word[31:16] : rd_word[15:0];
      unique case (rd_size)
         2'b00:   load_data = {{24{~rd_uns & byte_sh[7]}}, byte_sh[7:0]};
         2'b01:   load_data = {{16{~rd_uns & rd_half[15]}}, rd_half};
         default: load_data = rd_word;
      endcase
      if (rd_silent) load_data = 32'h0;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = StResp;
               end else begin
                  cnt_d   = 4'(WAIT_CYCLES - 1);
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) state_d = StResp;
            else cnt_d = cnt_q - 4'd1;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= 4'd0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= (state_d == StResp);
         if (state_d == StResp && state_q != StResp) begin
            resp_rdata_q <= load_data;
            resp_err_q   <= rd_err;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench: one instance without wait states, one with three.
module tb_data_mem_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid0, valid3;
   logic        ready0, ready3;
   logic        we, uns;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic        rv0, rv3, err0, err3;
   logic [31:0] rdata0, rdata3;

   logic [32:0] q0[$];
   logic [32:0] q3[$];
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   data_mem_lsu #(.DEPTH_WORDS(64), .ADDR_W(32), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(valid0), .req_ready(ready0), .req_we(we),
      .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
      .resp_valid(rv0), .resp_rdata(rdata0), .resp_err(err0)
   );

   data_mem_lsu #(.DEPTH_WORDS(64), .ADDR_W(32), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .req_valid(valid3), .req_ready(ready3), .req_we(we),
      .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
      .resp_valid(rv3), .resp_rdata(rdata3), .resp_err(err3)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [32:0] e;
      if (rv0) begin
         if (q0.size() == 0) check_eq("dut0_unexpected_resp", 1, 0);
         else begin
            e = q0.pop_front();
            check_eq("dut0_rdata", rdata0, e[31:0]);
            check_eq("dut0_err", err0, e[32]);
         end
      end
      if (rv3) begin
         if (q3.size() == 0) check_eq("dut3_unexpected_resp", 1, 0);
         else begin
            e = q3.pop_front();
            check_eq("dut3_rdata", rdata3, e[31:0]);
            check_eq("dut3_err", err3, e[32]);
         end
      end
   end

   task automatic drive(input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
      we = w; size = s; uns = u; addr = a; wdata = d;
   endtask

   task automatic do_req(input bit sel, input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic exp_err, input logic [31:0] exp_rdata);
      int n;
      @(negedge clk);
      n = 0;
      while (!(sel ? ready3 : ready0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n == 50) check_eq("ready_timeout", 0, 1);
      drive(w, s, u, a, d);
      if (sel) begin
         q3.push_back({exp_err, exp_rdata});
         valid3 = 1'b1;
      end else begin
         q0.push_back({exp_err, exp_rdata});
         valid0 = 1'b1;
      end
      @(posedge clk);
      #1;
      valid0 = 1'b0;
      valid3 = 1'b0;
      if (!sel) begin
         @(negedge clk);
         check_eq("dut0_latency", rv0, 1);
      end
      n = 0;
      while ((sel ? q3.size() : q0.size()) != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n == 50) check_eq("resp_timeout", 0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      valid0 = 1'b0;
      valid3 = 1'b0;
      drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      check_eq("rst_ready0", ready0, 1);
      check_eq("rst_valid0", rv0, 0);
      check_eq("rst_rdata0", rdata0, 0);
      check_eq("rst_err0", err0, 0);
      check_eq("rst_ready3", ready3, 1);
      check_eq("rst_valid3", rv3, 0);
      rst = 1'b0;

      // word store / load
      do_req(0, 1, 2'b10, 0, 32'h00, 32'h9F5D4A6E, 0, 32'h0);
      do_req(0, 0, 2'b10, 0, 32'h00, 32'h0, 0, 32'h9F5D4A6E);
      // byte store, signed / unsigned byte loads
      do_req(0, 1, 2'b00, 0, 32'h02, 32'h000000AB, 0, 32'h0);
      do_req(0, 0, 2'b00, 0, 32'h02, 32'h0, 0, 32'hFFFFFFAB);
      do_req(0, 0, 2'b00, 1, 32'h02, 32'h0, 0, 32'h000000AB);
      do_req(0, 0, 2'b10, 0, 32'h00, 32'h0, 0, 32'h9FAB4A6E);
      do_req(0, 0, 2'b01, 0, 32'h00, 32'h0, 0, 32'h00004A6E);
      // half store into upper half of word 1
      do_req(0, 1, 2'b10, 0, 32'h04, 32'h00000000, 0, 32'h0);
      do_req(0, 1, 2'b01, 0, 32'h06, 32'h00008001, 0, 32'h0);
      do_req(0, 0, 2'b01, 0, 32'h06, 32'h0, 0, 32'hFFFF8001);
      do_req(0, 0, 2'b01, 1, 32'h04, 32'h0, 0, 32'h00000000);
      do_req(0, 0, 2'b10, 0, 32'h04, 32'h0, 0, 32'h80010000);
      do_req(0, 0, 2'b00, 1, 32'h07, 32'h0, 0, 32'h00000080);
      do_req(0, 0, 2'b00, 0, 32'h05, 32'h0, 0, 32'h00000000);
      // faults: misaligned word, misaligned half store, out of range, illegal size store
      do_req(0, 0, 2'b10, 0, 32'h02, 32'h0, 1, 32'h0);
      do_req(0, 1, 2'b01, 0, 32'h03, 32'h0000FFFF, 1, 32'h0);
      do_req(0, 0, 2'b00, 0, 32'h100, 32'h0, 1, 32'h0);
      do_req(0, 1, 2'b11, 0, 32'h00, 32'hFFFFFFFF, 1, 32'h0);
      do_req(0, 0, 2'b10, 0, 32'h00, 32'h0, 0, 32'h9FAB4A6E);
      do_req(0, 0, 2'b10, 0, 32'h04, 32'h0, 0, 32'h80010000);
      repeat (2) @(negedge clk);
      check_eq("rdata_hold", rdata0, 32'h80010000);
      check_eq("valid_low_idle", rv0, 0);

      // wait-state timing
      do_req(1, 1, 2'b10, 0, 32'h00, 32'h11223344, 0, 32'h0);
      @(negedge clk);
      check_eq("w3_ready_pre", ready3, 1);
      drive(1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
      q3.push_back({1'b0, 32'h11223344});
      valid3 = 1'b1;
      @(posedge clk);
      #1 valid3 = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check_eq("w3_ready", ready3, (k == 5));
         check_eq("w3_valid", rv3, (k == 4));
      end
      check_eq("w3_queue_empty", q3.size(), 0);

      // reset while waiting drops the response but keeps the store
      @(negedge clk);
      drive(1'b1, 2'b10, 1'b0, 32'h08, 32'h12345678);
      valid3 = 1'b1;
      @(posedge clk);
      #1 valid3 = 1'b0;
      @(negedge clk);
      check_eq("w3_in_wait", ready3, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("rst_mid_ready", ready3, 1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check_eq("rst_mid_no_resp", rv3, 0);
      end
      do_req(1, 0, 2'b10, 0, 32'h08, 32'h0, 0, 32'h12345678);
      do_req(1, 0, 2'b00, 0, 32'h0B, 32'h0, 0, 32'h00000012);

      repeat (3) @(negedge clk);
      check_eq("q0_drained", q0.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
